// File: rtl/switch_debounce_filter.sv
// Debounce filter for one mechanical switch: clean level, rise/fall strobes and an LED toggle.
// Optional macro DEBOUNCE_SYNC_EN adds a 2-flop synchroniser ahead of the filter.
module switch_debounce_filter #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter logic INIT_LEVEL     = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Busy,
    output logic o_LED_Toggle
);

    localparam int            CW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          switch_q, switch_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;
    logic          led_q, led_d;
    logic          sample_q;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q  <= INIT_LEVEL;
            sample_q <= INIT_LEVEL;
        end else begin
            sync1_q  <= i_Switch;
            sample_q <= sync1_q;
        end
    end
`else
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sample_q <= INIT_LEVEL;
        end else begin
            sample_q <= i_Switch;
        end
    end
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            switch_q <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            switch_q <= switch_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sample_q != switch_q) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (sample_q == switch_q || count_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The count holds the number of consecutive differing samples seen so far;
    // the sample that would make it DEBOUNCE_LIMIT commits the new level instead.
    always_comb begin
        count_d  = count_q;
        switch_d = switch_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        led_d    = led_q;
        busy_d   = (state_d == COUNT);
        case (state_q)
            IDLE: begin
                count_d = (sample_q != switch_q) ? CW'(1) : '0;
            end
            COUNT: begin
                if (sample_q == switch_q) begin
                    count_d = '0;
                end else if (count_q == LAST) begin
                    count_d  = '0;
                    switch_d = sample_q;
                    rise_d   = sample_q;
                    fall_d   = ~sample_q;
                    led_d    = led_q ^ sample_q;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: count_d = '0;
        endcase
    end

    assign o_Switch     = switch_q;
    assign o_Rise       = rise_q;
    assign o_Fall       = fall_q;
    assign o_Busy       = busy_q;
    assign o_LED_Toggle = led_q;

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed self-checking bench for switch_debounce_filter with DEBOUNCE_LIMIT=4, INIT_LEVEL=0.
// Latency expectations shift by one cycle when DEBOUNCE_SYNC_EN is defined.
module tb_switch_debounce_filter;

`ifdef DEBOUNCE_SYNC_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int ACCEPT = 4 + EXTRA;

    logic i_Clk;
    logic i_Rst;
    logic i_Switch;
    logic o_Switch;
    logic o_Rise;
    logic o_Fall;
    logic o_Busy;
    logic o_LED_Toggle;

    int checks   = 0;
    int failures = 0;
    int riseSeen = 0;
    int fallSeen = 0;

    switch_debounce_filter #(
        .DEBOUNCE_LIMIT(4),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Switch    (i_Switch),
        .o_Switch    (o_Switch),
        .o_Rise      (o_Rise),
        .o_Fall      (o_Fall),
        .o_Busy      (o_Busy),
        .o_LED_Toggle(o_LED_Toggle)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            if (o_Rise) riseSeen++;
            if (o_Fall) fallSeen++;
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int step, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s step=%0d observed=%b expected=%b", tag, step, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed == expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one debounced transition to 'level' (or releases reset with the
    // switch already at 'level') and checks every cycle until it settles.
    task automatic applyStimulus(input logic level, input logic ledBefore, input logic fromReset);
        if (fromReset) i_Rst = 1'b0;
        else           i_Switch = level;
        for (int k = 0; k <= ACCEPT + 1; k++) begin
            tick();
            checkOutput("sw",   k, o_Switch, (k >= ACCEPT) ? level : ~level);
            checkOutput("rise", k, o_Rise,   level && (k == ACCEPT));
            checkOutput("fall", k, o_Fall,   !level && (k == ACCEPT));
            checkOutput("busy", k, o_Busy,   (k >= 1 + EXTRA) && (k <= 3 + EXTRA));
            checkOutput("led",  k, o_LED_Toggle, (level && k >= ACCEPT) ? ~ledBefore : ledBefore);
        end
    endtask

    initial begin
        int busyCycles;
        int riseBase;
        int fallBase;

        $display("[TB] start, EXTRA=%0d", EXTRA);
        i_Rst    = 1'b1;
        i_Switch = 1'b0;
        tick();
        tick();
        checkOutput("rst_sw",   0, o_Switch, 1'b0);
        checkOutput("rst_rise", 0, o_Rise, 1'b0);
        checkOutput("rst_fall", 0, o_Fall, 1'b0);
        checkOutput("rst_busy", 0, o_Busy, 1'b0);
        checkOutput("rst_led",  0, o_LED_Toggle, 1'b0);
        i_Rst = 1'b0;
        repeat (3) tick();

        // Bounce: 1,1,1,0 five times never reaches four differing samples.
        busyCycles = 0;
        for (int j = 0; j < 24; j++) begin
            i_Switch = (j < 20) && ((j % 4) != 3);
            tick();
            if (o_Busy) busyCycles++;
            checkOutput("bnc_sw",   j, o_Switch, 1'b0);
            checkOutput("bnc_rise", j, o_Rise, 1'b0);
            checkOutput("bnc_fall", j, o_Fall, 1'b0);
        end
        checkCount("bnc_busy_cycles", busyCycles, 15);

        $display("[TB] clean press and release");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] reset during count");
        i_Switch = 1'b1;
        repeat (3) tick();
        checkOutput("pre_rst_busy", 0, o_Busy, 1'b1);
        checkOutput("pre_rst_led",  0, o_LED_Toggle, 1'b1);
        i_Rst = 1'b1;
        #1;
        checkOutput("arst_busy", 0, o_Busy, 1'b0);
        checkOutput("arst_led",  0, o_LED_Toggle, 1'b0);
        checkOutput("arst_sw",   0, o_Switch, 1'b0);
        tick();
        tick();
        checkOutput("hold_busy", 0, o_Busy, 1'b0);
        riseBase = riseSeen;
        fallBase = fallSeen;
        applyStimulus(1'b1, 1'b0, 1'b1);

        $display("[TB] two presses");
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkCount("rise_pulses", riseSeen - riseBase, 2);
        checkCount("fall_pulses", fallSeen - fallBase, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
